phys_reg_alloc: RTL and testbench
=================================

# phys_reg_alloc

Physical-register allocator and busy-bit scoreboard for the renamed register file. It holds the free list of physical register tags and hands one tag per cycle to the rename stage for each new destination register. Tags come back to the free list when the commit stage retires the previous mapping. It also owns the busy bit of every physical register: set on allocation, cleared on write-back. Issue logic queries the busy bits for rs/rt.

## Interface
Parameters:
- NUM_PHYS, 64, number of physical registers (power of two)
- NUM_ARCH, 32, number of architectural registers
- TAG_W, 6, log2(NUM_PHYS)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- alloc_req  in  1  rename needs a destination tag this cycle
- alloc_ready  out  1  free list non-empty
- alloc_tag  out  TAG_W  tag granted; valid when alloc_ready
- free_valid  in  1  commit returns a tag
- free_tag  in  TAG_W  tag being returned
- wb_valid  in  1  write-back writes a physical register
- wb_tag  in  TAG_W  tag written
- rs_tag, rt_tag  in  TAG_W each  issue-stage source tags to query
- rs_busy, rt_busy  out  1 each  source not yet written
- busy_bits  out  NUM_PHYS  full scoreboard vector
- free_count  out  TAG_W+1  entries in the free list
- overflow_err  out  1  sticky: free arrived with list full, or tag 0 freed

## Operation
- Free list: circular FIFO with NUM_PHYS-1 entries of TAG_W bits, plus head/tail pointers and a count. The head/tail pointers wrap modulo NUM_PHYS-1.
- Reset state:
  - entries 0..NUM_PHYS-NUM_ARCH-1 hold tags NUM_ARCH..NUM_PHYS-1 in ascending order
  - head=0, tail=NUM_PHYS-NUM_ARCH, count=NUM_PHYS-NUM_ARCH
  - busy_bits=0, overflow_err=0
- Architectural register i initially maps to physical register i.
- Allocation: alloc_tag = entry[head]; alloc_ready = (count != 0). The pop happens on a clock edge where alloc_req && alloc_ready. If alloc_req is high while alloc_ready is low, nothing happens and the requester must hold.
- Free: on free_valid, the tag is pushed at tail.
  - If free_tag == 0 or count == NUM_PHYS-1, the push is dropped and overflow_err is set.
  - overflow_err stays set until rst.
- Simultaneous alloc+free: push and pop both happen and count is unchanged. There is no bypass: when count == 0, a same-cycle free does not satisfy the alloc. alloc_ready depends on registered count only.
- Busy bits:
  - a granted alloc sets busy[alloc_tag] at the edge
  - wb_valid clears busy[wb_tag] at the edge
  - if both target the same tag in one cycle, the set wins
  - wb_tag == 0 is ignored
- Phys register 0 ($zero) is never in the free list and is never busy.
- Busy query: rs_busy = busy[rs_tag] && !(wb_valid && wb_tag == rs_tag). rt_busy is the same with rt_tag. This forwards same-cycle write-back, matching the register file's write-then-read behaviour.
- No flush/checkpoint support in this revision. A pipeline flush requires rst.

## Timing
- alloc_tag, alloc_ready, rs_busy, rt_busy are combinational from registered state plus wb inputs. All other outputs are registered.
- Allocation latency is 0 cycles: the tag is usable in the same cycle as the grant. The next tag appears the cycle after.
- A freed tag can be allocated at the earliest 1 cycle after free_valid.
- Busy is set 1 cycle after the grant and cleared 1 cycle after wb_valid. The query sees the clear in the same cycle through the forward path.
- Throughput: one alloc, one free and one wb per cycle, all concurrently.
- rst asserted in any cycle overrides all inputs in that cycle and restores the reset state at the next edge.

## Structure
- Shared package mips_core_pkg holds:
  - typedef phys_tag_t (logic [TAG_W-1:0])
  - constants NUM_PHYS and NUM_ARCH
  - constant PHYS_ZERO = 0
- One sub-module, phys_free_fifo: circular buffer with pointers and count, supporting push and pop in the same cycle and a parameterised reset fill.
- The scoreboard, busy forwarding and error logic live in the top module.

## Test plan
- Reset then idle: alloc_ready=1, alloc_tag=32, free_count=32, busy_bits=0, overflow_err=0.
- 32 back-to-back allocs:
  - tags granted are 32..63 in order
  - busy[32..63]=1 one cycle after each grant
  - afterwards alloc_ready=0 and free_count=0
  - a 33rd alloc_req is not granted
- With the list empty, free_tag=5 and alloc_req in the same cycle: no grant that cycle. The next cycle gives alloc_ready=1, alloc_tag=5, and a grant then returns free_count to 0.
- alloc tag 40 in cycle N; wb_tag=40 in cycle N+3:
  - rs_tag=40 reads rs_busy=1 in cycles N+1 and N+2
  - rs_busy=0 in cycle N+3 (forwarded)
  - busy[40]=0 from N+4
- Same-cycle alloc of tag 33 and wb_tag=33 (stale): busy[33]=1 afterwards.
- Error cases:
  - free_tag=0 sets overflow_err=1 and leaves free_count unchanged
  - free at count=63 also sets it
  - rst mid-allocation stream restores alloc_tag=32, free_count=32, overflow_err=0

Source files
------------

// File: rtl/mips_core_pkg.sv
// mips_core_pkg
// Shared constants and types for the renamed register file.
//   NUM_PHYS   - physical register count (power of two)
//   NUM_ARCH   - architectural register count
//   TAG_W      - width of a physical register tag
//   phys_tag_t - physical register tag type
//   PHYS_ZERO  - tag of the hard-wired $zero physical register
package mips_core_pkg;

  localparam int NUM_PHYS = 64;
  localparam int NUM_ARCH = 32;
  localparam int TAG_W    = 6;

  typedef logic [TAG_W-1:0] phys_tag_t;

  localparam phys_tag_t PHYS_ZERO = {TAG_W{1'b0}};

endpackage

// File: rtl/phys_free_fifo.sv
// phys_free_fifo
// Circular buffer of free physical register tags with head/tail pointers and
// an occupancy count. Push and pop may happen in the same cycle. On reset the
// first FILL_COUNT entries are loaded with consecutive tags starting at
// FILL_BASE.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   push       - write push_tag at tail (caller guarantees not full)
//   push_tag   - tag to write
//   pop        - advance head (caller guarantees not empty)
//   head_tag   - entry at head
//   count      - number of valid entries (registered)
module phys_free_fifo #(
  parameter int DEPTH      = 63,
  parameter int TAG_W      = 6,
  parameter int FILL_COUNT = 32,
  parameter int FILL_BASE  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic [TAG_W-1:0] head_tag,
  output logic [TAG_W:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [TAG_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  // Pointer increment with wrap at DEPTH (not a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Next-state for storage, pointers and count.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      mem_d[tail_q] = push_tag;
      tail_d        = ptr_inc(tail_q);
    end else begin
      tail_d = tail_q;
    end
    if (pop) begin
      head_d = ptr_inc(head_q);
    end else begin
      head_d = head_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (TAG_W+1)'(1);
      2'b01:   count_d = count_q - (TAG_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with reset fill of the initial free tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= (i < FILL_COUNT) ? TAG_W'(FILL_BASE + i) : {TAG_W{1'b0}};
      end
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= PTR_W'(FILL_COUNT % DEPTH);
      count_q <= (TAG_W+1)'(FILL_COUNT);
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_tag = mem_q[head_q];
  assign count    = count_q;

endmodule

// File: rtl/phys_reg_alloc.sv
// phys_reg_alloc
// Physical-register allocator and busy-bit scoreboard. Hands out one free tag
// per cycle to rename, accepts returned tags from commit, and tracks which
// physical registers are still waiting for write-back.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   alloc_req              - rename wants a destination tag
//   alloc_ready, alloc_tag - free list non-empty / tag at head (combinational)
//   free_valid, free_tag   - commit returns a tag
//   wb_valid, wb_tag       - write-back of a physical register
//   rs_tag/rt_tag          - issue source tags to query
//   rs_busy/rt_busy        - source still pending (with same-cycle wb forward)
//   busy_bits              - full scoreboard (registered)
//   free_count             - free list occupancy (registered)
//   overflow_err           - sticky: push with list full, or tag 0 returned
module phys_reg_alloc
  import mips_core_pkg::*;
#(
  parameter int NUM_PHYS = mips_core_pkg::NUM_PHYS,
  parameter int NUM_ARCH = mips_core_pkg::NUM_ARCH,
  parameter int TAG_W    = mips_core_pkg::TAG_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_req,
  output logic                alloc_ready,
  output logic [TAG_W-1:0]    alloc_tag,
  input  logic                free_valid,
  input  logic [TAG_W-1:0]    free_tag,
  input  logic                wb_valid,
  input  logic [TAG_W-1:0]    wb_tag,
  input  logic [TAG_W-1:0]    rs_tag,
  input  logic [TAG_W-1:0]    rt_tag,
  output logic                rs_busy,
  output logic                rt_busy,
  output logic [NUM_PHYS-1:0] busy_bits,
  output logic [TAG_W:0]      free_count,
  output logic                overflow_err
);

  localparam int DEPTH = NUM_PHYS - 1;
  localparam logic [TAG_W-1:0] ZERO_TAG = TAG_W'(PHYS_ZERO);

  logic [NUM_PHYS-1:0] busy_q, busy_d;
  logic                overflow_q, overflow_d;
  logic [TAG_W:0]      count_s;
  logic [TAG_W-1:0]    head_tag_s;
  logic                grant_s;
  logic                full_s;
  logic                bad_free_s;
  logic                push_s;

  phys_free_fifo #(
    .DEPTH      (DEPTH),
    .TAG_W      (TAG_W),
    .FILL_COUNT (NUM_PHYS - NUM_ARCH),
    .FILL_BASE  (NUM_ARCH)
  ) u_free_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_s),
    .push_tag (free_tag),
    .pop      (grant_s),
    .head_tag (head_tag_s),
    .count    (count_s)
  );

  // Grant/push decisions. Readiness depends only on the registered count, so
  // a tag freed this cycle cannot satisfy an allocation in the same cycle.
  always_comb begin
    alloc_ready = (count_s != (TAG_W+1)'(0));
    grant_s     = alloc_req && alloc_ready;
    full_s      = (count_s == (TAG_W+1)'(DEPTH));
    bad_free_s  = free_valid && ((free_tag == ZERO_TAG) || full_s);
    push_s      = free_valid && !bad_free_s;
  end

  // Scoreboard next state: wb clears first so a same-tag grant overrides the
  // stale write-back; $zero is forced clear.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid && (wb_tag != ZERO_TAG)) begin
      busy_d[wb_tag] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (grant_s) begin
      busy_d[head_tag_s] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
    overflow_d = overflow_q || bad_free_s;
  end

  // Scoreboard and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= {NUM_PHYS{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  // Source queries forward a same-cycle write-back.
  always_comb begin
    rs_busy = busy_q[rs_tag] && !(wb_valid && (wb_tag == rs_tag));
    rt_busy = busy_q[rt_tag] && !(wb_valid && (wb_tag == rt_tag));
  end

  assign alloc_tag    = head_tag_s;
  assign busy_bits    = busy_q;
  assign free_count   = count_s;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_phys_reg_alloc.sv
// tb_phys_reg_alloc
// Directed bench for phys_reg_alloc with hand-computed expectations.
module tb_phys_reg_alloc;

  logic        clk;
  logic        rst;
  logic        alloc_req;
  logic        alloc_ready;
  logic [5:0]  alloc_tag;
  logic        free_valid;
  logic [5:0]  free_tag;
  logic        wb_valid;
  logic [5:0]  wb_tag;
  logic [5:0]  rs_tag;
  logic [5:0]  rt_tag;
  logic        rs_busy;
  logic        rt_busy;
  logic [63:0] busy_bits;
  logic [6:0]  free_count;
  logic        overflow_err;

  int n_checks;
  int n_pass;

  phys_reg_alloc dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_req    (alloc_req),
    .alloc_ready  (alloc_ready),
    .alloc_tag    (alloc_tag),
    .free_valid   (free_valid),
    .free_tag     (free_tag),
    .wb_valid     (wb_valid),
    .wb_tag       (wb_tag),
    .rs_tag       (rs_tag),
    .rt_tag       (rt_tag),
    .rs_busy      (rs_busy),
    .rt_busy      (rt_busy),
    .busy_bits    (busy_bits),
    .free_count   (free_count),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    alloc_req  = 1'b0;
    free_valid = 1'b0;
    free_tag   = 6'd0;
    wb_valid   = 1'b0;
    wb_tag     = 6'd0;
    rs_tag     = 6'd0;
    rt_tag     = 6'd0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_ready", alloc_ready, 64'd1);
    check("rst_tag", alloc_tag, 64'd32);
    check("rst_count", free_count, 64'd32);
    check("rst_busy", busy_bits, 64'd0);
    check("rst_ovf", overflow_err, 64'd0);

    // Drain the whole initial free list.
    for (int i = 0; i < 32; i++) begin
      alloc_req = 1'b1;
      #1;
      check("drain_ready", alloc_ready, 64'd1);
      check("drain_tag", alloc_tag, 64'(32 + i));
      tick();
      check("drain_busy", busy_bits[32+i], 64'd1);
      check("drain_count", free_count, 64'(31 - i));
    end
    #1;
    check("empty_ready", alloc_ready, 64'd0);
    check("empty_count", free_count, 64'd0);
    tick();
    check("no33_count", free_count, 64'd0);
    check("no33_busy", busy_bits, 64'hFFFF_FFFF_0000_0000);

    // Free into an empty list while requesting: no bypass.
    free_valid = 1'b1;
    free_tag   = 6'd5;
    #1;
    check("nobypass_ready", alloc_ready, 64'd0);
    tick();
    free_valid = 1'b0;
    #1;
    check("freed_ready", alloc_ready, 64'd1);
    check("freed_tag", alloc_tag, 64'd5);
    check("freed_count", free_count, 64'd1);
    tick();
    alloc_req = 1'b0;
    #1;
    check("regrant_count", free_count, 64'd0);
    check("regrant_busy5", busy_bits[5], 64'd1);

    // Tag 40: clear and return, allocate at N, write back at N+3.
    wb_valid   = 1'b1;
    wb_tag     = 6'd40;
    free_valid = 1'b1;
    free_tag   = 6'd40;
    tick();
    wb_valid   = 1'b0;
    free_valid = 1'b0;
    alloc_req  = 1'b1;
    rs_tag     = 6'd40;
    rt_tag     = 6'd41;
    #1;
    check("n_tag", alloc_tag, 64'd40);
    check("n_rs", rs_busy, 64'd0);
    check("n_rt41", rt_busy, 64'd1);
    tick();
    alloc_req = 1'b0;
    #1;
    check("n1_rs", rs_busy, 64'd1);
    tick();
    check("n2_rs", rs_busy, 64'd1);
    tick();
    wb_valid = 1'b1;
    wb_tag   = 6'd40;
    #1;
    check("n3_rs_fwd", rs_busy, 64'd0);
    check("n3_busy40", busy_bits[40], 64'd1);
    tick();
    wb_valid = 1'b0;
    #1;
    check("n4_busy40", busy_bits[40], 64'd0);
    check("n4_rs", rs_busy, 64'd0);

    // Tag 33: grant and stale write-back of the same tag in one cycle.
    wb_valid   = 1'b1;
    wb_tag     = 6'd33;
    free_valid = 1'b1;
    free_tag   = 6'd33;
    tick();
    free_valid = 1'b0;
    alloc_req  = 1'b1;
    rt_tag     = 6'd33;
    #1;
    check("t33_tag", alloc_tag, 64'd33);
    check("t33_rt_fwd", rt_busy, 64'd0);
    tick();
    alloc_req = 1'b0;
    wb_valid  = 1'b0;
    #1;
    check("t33_busy", busy_bits[33], 64'd1);
    check("t33_rt", rt_busy, 64'd1);

    // Returning tag 0 is an error and is dropped.
    check("pre_ovf", overflow_err, 64'd0);
    free_valid = 1'b1;
    free_tag   = 6'd0;
    tick();
    free_valid = 1'b0;
    #1;
    check("zero_ovf", overflow_err, 64'd1);
    check("zero_count", free_count, 64'd0);
    tick();
    check("ovf_sticky", overflow_err, 64'd1);

    // Reset, fill to 63, then one more free overflows.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst2_ovf", overflow_err, 64'd0);
    check("rst2_count", free_count, 64'd32);
    for (int t = 1; t < 32; t++) begin
      free_valid = 1'b1;
      free_tag   = 6'(t);
      tick();
    end
    free_valid = 1'b0;
    #1;
    check("full_count", free_count, 64'd63);
    check("full_ovf", overflow_err, 64'd0);
    free_valid = 1'b1;
    free_tag   = 6'd7;
    tick();
    free_valid = 1'b0;
    #1;
    check("full_ovf_set", overflow_err, 64'd1);
    check("full_count_hold", free_count, 64'd63);

    // Pop the 32 reset tags; the head then reaches the first returned tag.
    alloc_req = 1'b1;
    repeat (32) tick();
    alloc_req = 1'b0;
    #1;
    check("wrap_tag", alloc_tag, 64'd1);
    check("wrap_count", free_count, 64'd31);

    // Reset in the middle of an allocation stream.
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    alloc_req = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    alloc_req = 1'b0;
    #1;
    check("midrst_tag", alloc_tag, 64'd32);
    check("midrst_count", free_count, 64'd32);
    check("midrst_ovf", overflow_err, 64'd0);
    check("midrst_busy", busy_bits, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
